// File: rtl/gl_pkg.sv
// Shared definitions for the gl_fetch instruction fetch unit.
// Holds the opcode constants, the instruction field positions, the FSM
// state enumeration and the fetched-word record.
package gl_pkg;

  localparam logic [7:0] OP_NOP  = 8'hFF;
  localparam logic [7:0] OP_HALT = 8'hFE;

  // Instruction word layout: opcode[31:24], type[23], imm[22:0]
  localparam int OPC_MSB  = 31;
  localparam int OPC_LSB  = 24;
  localparam int TYPE_BIT = 23;
  localparam int IMM_MSB  = 22;
  localparam int IMM_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // One fetched instruction together with the word address it came from
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] word;
  } fetch_t;

  function automatic logic is_halt(input logic [31:0] w);
    return w[OPC_MSB:OPC_LSB] == OP_HALT;
  endfunction

endpackage

// File: rtl/gl_fetch_fifo.sv
// Purpose : 2-entry synchronous prefetch FIFO of fetched instructions.
// Latency : push visible on head_dat the cycle after the push edge.
// Backpr. : caller must not push when full unless it pops the same cycle.
// Ports   : clk/rst, push + push_dat, pop, head_dat, full, empty, count.
module gl_fetch_fifo
  import gl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  fetch_t     push_dat,
  input  logic       pop,
  output fetch_t     head_dat,
  output logic       full,
  output logic       empty,
  output logic [1:0] count
);

  fetch_t [1:0] mem_q, mem_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    // At full, wr_ptr == rd_ptr: the head is read out before the edge, so
    // overwriting it on a simultaneous push/pop is safe.
    if (push) mem_d[wr_ptr_q] = push_dat;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign full     = (cnt_q == 2'd2);
  assign empty    = (cnt_q == 2'd0);
  assign count    = cnt_q;

endmodule

// File: rtl/gl_fetch.sv
// Purpose : instruction fetch; reads imem from START_ADDR, presents each
//           instruction to decode for >= ISSUE_HOLD cycles, stops on OP_HALT.
// Latency : imem data registered the cycle after imem_en; issue next cycle.
// Backpr. : stall (after the hold count expires) freezes all outputs.
// Ports   : clk, rst (async, active high), start pulse, imem_en/imem_addr/
//           imem_data read port, stall, decoded opcode/instr_type/imm,
//           operand_addr, valid, done, pc. instr_type carries word bit [23]
//           (the name "type" is a SystemVerilog reserved word).
// Config  : GL_FETCH_PREFETCH_EN adds a 2-entry prefetch FIFO so that
//           unstalled instructions issue back to back every ISSUE_HOLD
//           cycles; without it one read is made per advance (one NOP gap).
module gl_fetch
  import gl_pkg::*;
#(
  parameter int unsigned ISSUE_HOLD = 2,
  parameter logic [31:0] START_ADDR = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  output logic [7:0]  opcode,
  output logic        instr_type,
  output logic [22:0] imm,
  output logic [31:0] operand_addr,
  output logic        valid,
  output logic        done,
  output logic [31:0] pc
);

  localparam logic [3:0] HOLD_INIT = 4'(ISSUE_HOLD - 1);

  state_t      state_q, state_d;
  logic [31:0] imem_addr_q, imem_addr_d;
  logic [31:0] rd_addr_q, rd_addr_d;     // address of the read in flight
  logic        rd_pend_q, rd_pend_d;     // imem_data holds a read this cycle
  logic        halt_seen_q, halt_seen_d;
  logic [7:0]  opcode_q, opcode_d;
  logic        type_q, type_d;
  logic [22:0] imm_q, imm_d;
  logic        valid_q, valid_d;
  logic [3:0]  hold_q, hold_d;
  logic [31:0] pc_q, pc_d;

  logic        run, advance, slot_free, src_vld, load, rd_en, halt_arr, halt_go;
  fetch_t      arr, src;

`ifdef GL_FETCH_PREFETCH_EN
  logic        fifo_push, fifo_full, fifo_empty;
  logic [1:0]  fifo_cnt;
  logic [2:0]  occ;
  fetch_t      fifo_head;

  gl_fetch_fifo u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat (arr),
    .pop      (load),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_cnt)
  );
`endif

  always_comb begin
    run       = (state_q == ST_RUN);
    advance   = valid_q && (hold_q == 4'd0) && !stall;
    slot_free = !valid_q || advance;
    arr       = {rd_addr_q, imem_data};
    halt_arr  = rd_pend_q && !halt_seen_q && is_halt(imem_data);
`ifdef GL_FETCH_PREFETCH_EN
    fifo_push = rd_pend_q && !halt_seen_q && !is_halt(imem_data);
    src_vld   = !fifo_empty;
    src       = fifo_head;
    load      = run && slot_free && src_vld;
    // The read in flight already owns a slot, so count it with the FIFO.
    occ       = {1'b0, fifo_cnt} + {2'b00, rd_pend_q} - {2'b00, load};
    rd_en     = run && !halt_seen_q && !halt_arr && (occ < 3'd2)
                && !(fifo_full && !load);
`else
    src_vld   = rd_pend_q && !halt_seen_q && !is_halt(imem_data);
    src       = arr;
    load      = run && slot_free && src_vld;
    // One outstanding word at a time: read only once the output slot frees.
    rd_en     = run && !halt_seen_q && !rd_pend_q && slot_free;
`endif
    // HALT once everything fetched before OP_HALT has been advanced.
    halt_go   = run && halt_seen_q && !src_vld && slot_free;

    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)   state_d = ST_RUN;
      ST_RUN:  if (halt_go) state_d = ST_HALT;
      default: state_d = state_q;
    endcase

    imem_addr_d = rd_en ? imem_addr_q + 32'd1 : imem_addr_q;
    rd_addr_d   = rd_en ? imem_addr_q : rd_addr_q;
    rd_pend_d   = rd_en;
    halt_seen_d = halt_seen_q || halt_arr;

    opcode_d = opcode_q;
    type_d   = type_q;
    imm_d    = imm_q;
    valid_d  = valid_q;
    hold_d   = hold_q;
    pc_d     = pc_q;
    if (load) begin
      opcode_d = src.word[OPC_MSB:OPC_LSB];
      type_d   = src.word[TYPE_BIT];
      imm_d    = src.word[IMM_MSB:IMM_LSB];
      valid_d  = 1'b1;
      hold_d   = HOLD_INIT;
      pc_d     = src.addr;
    end else if (advance) begin
      opcode_d = OP_NOP;
      type_d   = 1'b0;
      imm_d    = '0;
      valid_d  = 1'b0;
      hold_d   = 4'd0;
    end else if (hold_q != 4'd0) begin
      hold_d   = hold_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      imem_addr_q <= START_ADDR;
      rd_addr_q   <= START_ADDR;
      rd_pend_q   <= 1'b0;
      halt_seen_q <= 1'b0;
      opcode_q    <= OP_NOP;
      type_q      <= 1'b0;
      imm_q       <= '0;
      valid_q     <= 1'b0;
      hold_q      <= 4'd0;
      pc_q        <= START_ADDR;
    end else begin
      state_q     <= state_d;
      imem_addr_q <= imem_addr_d;
      rd_addr_q   <= rd_addr_d;
      rd_pend_q   <= rd_pend_d;
      halt_seen_q <= halt_seen_d;
      opcode_q    <= opcode_d;
      type_q      <= type_d;
      imm_q       <= imm_d;
      valid_q     <= valid_d;
      hold_q      <= hold_d;
      pc_q        <= pc_d;
    end
  end

  assign imem_en      = rd_en;
  assign imem_addr    = imem_addr_q;
  assign opcode       = opcode_q;
  assign instr_type   = type_q;
  assign imm          = imm_q;
  assign operand_addr = {9'd0, imm_q};
  assign valid        = valid_q;
  assign done         = (state_q == ST_HALT);
  assign pc           = pc_q;

endmodule

// File: tb/tb_gl_fetch.sv
// Bench for gl_fetch: memory model, scoreboard queue of expected issues,
// and a monitor that checks issue order, hold timing and NOP fields.
module tb_gl_fetch;
  import gl_pkg::*;

  localparam int          H     = 2;
  localparam logic [31:0] START = 32'hFFFF_FFFF;
`ifdef GL_FETCH_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  logic        clk, rst, start, stall, imem_en, itype, valid, done;
  logic [31:0] imem_addr, imem_data, operand_addr, pc;
  logic [7:0]  opcode;
  logic [22:0] imm;

  gl_fetch #(.ISSUE_HOLD(H), .START_ADDR(START)) dut (
    .clk(clk), .rst(rst), .start(start), .imem_en(imem_en),
    .imem_addr(imem_addr), .imem_data(imem_data), .stall(stall),
    .opcode(opcode), .instr_type(itype), .imm(imm),
    .operand_addr(operand_addr), .valid(valid), .done(done), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] word; } exp_t;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] prog [$];
  exp_t        exp_q [$];
  int          checks = 0;
  int          failures = 0;

  // Synchronous read memory: data one cycle after imem_en, garbage otherwise
  always @(posedge clk) begin
    if (imem_en && mem.exists(imem_addr)) imem_data <= mem[imem_addr];
    else                                  imem_data <= $urandom();
  end

  task automatic chk(input bit ok, input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int          k;
  bit          prev_adv, want_new, cur_vld, new_iss, ev;
  logic [31:0] rd_exp, cur_pc;
  logic [31:0] cur_word;
  exp_t        mon_e;

  always @(negedge clk or posedge rst) begin
    if (rst) begin
      k = 0; prev_adv = 0; want_new = 0; cur_vld = 0; rd_exp = START;
    end else begin
      if (imem_en) begin
        chk(imem_addr == rd_exp, "read_addr", imem_addr, rd_exp);
        rd_exp = rd_exp + 32'd1;
      end
      new_iss = 1'b0;
      if (prev_adv) begin
        // After an advance: prefetch shows the next word at once, the
        // single-buffer build shows exactly one NOP cycle.
        ev = PF && (exp_q.size() > 0);
        chk(valid == ev, "after_advance_valid", valid, ev);
        new_iss  = valid;
        want_new = !valid;
      end else if (want_new) begin
        want_new = 1'b0;
        if (exp_q.size() > 0) begin
          chk(valid, "issue_after_nop", valid, 1);
          new_iss = valid;
        end
      end else if (cur_vld) begin
        chk(valid && {opcode, itype, imm} == cur_word && pc == cur_pc,
            "hold_stable", {opcode, itype, imm, pc}, {cur_word, cur_pc});
      end else if (valid) begin
        new_iss = 1'b1;
      end
      if (new_iss) begin
        chk(exp_q.size() > 0, "extra_issue", {opcode, itype, imm}, 0);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk({opcode, itype, imm} == mon_e.word, "issue_word",
              {opcode, itype, imm}, mon_e.word);
          chk(pc == mon_e.addr, "issue_pc", pc, mon_e.addr);
          chk(operand_addr == {9'd0, mon_e.word[22:0]}, "operand_addr",
              operand_addr, {9'd0, mon_e.word[22:0]});
        end
        k = 0;
      end
      if (!valid)
        chk(opcode == 8'hFF && itype == 1'b0 && imm == 23'd0 && operand_addr == 32'd0,
            "nop_fields", {opcode, itype, imm, operand_addr}, {8'hFF, 56'd0});
      prev_adv = valid && (k >= H - 1) && !stall;
      k        = k + 1;
      cur_vld  = valid;
      cur_word = {opcode, itype, imm};
      cur_pc   = pc;
    end
  end

  // ---------------- stimulus ----------------
  task automatic load();
    bit          seen_halt;
    logic [31:0] w, a;
    exp_t        e;
    mem.delete();
    exp_q.delete();
    seen_halt = 1'b0;
    for (int i = 0; i < prog.size(); i++) begin
      w = prog[i];
      a = START + 32'(i);
      mem[a] = w;
      if (w[31:24] == OP_HALT) seen_halt = 1'b1;
      if (!seen_halt) begin
        e.addr = a; e.word = w;
        exp_q.push_back(e);
      end
    end
    for (int j = 0; j < 4; j++) mem[START + 32'(prog.size() + j)] = $urandom();
  endtask

  task automatic rand_prog(input int n);
    logic [31:0] r;
    logic [7:0]  op;
    prog.delete();
    for (int i = 0; i < n; i++) begin
      r  = $urandom();
      op = 8'($urandom_range(0, 253));
      prog.push_back({op, r[23:0]});
    end
    r = $urandom();
    prog.push_back({OP_HALT, r[23:0]});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3 rst = 1'b1;
    exp_q.delete();
    stall = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic check_reset(input string nm);
    chk({imem_en, valid, done, opcode, itype, imm} == {3'b000, 8'hFF, 24'd0},
        {nm, "_ctrl"}, {imem_en, valid, done, opcode, itype, imm}, {3'b000, 8'hFF, 24'd0});
    chk({imem_addr, pc} == {START, START}, {nm, "_addr_pc"}, {imem_addr, pc}, {START, START});
    chk(operand_addr == 32'd0, {nm, "_operand"}, operand_addr, 0);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (valid) break;
    end
    chk(valid, "wait_valid_timeout", valid, 1);
  endtask

  task automatic run_to_done(input string nm, input int pct);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      stall = (pct > 0) && ($urandom_range(0, 99) < pct);
      if (done) break;
    end
    stall = 1'b0;
    chk(done, {nm, "_done"}, done, 1);
    chk({valid, imem_en, opcode} == {2'b00, 8'hFF}, {nm, "_halt_outputs"},
        {valid, imem_en, opcode}, {2'b00, 8'hFF});
    chk(exp_q.size() == 0, {nm, "_all_issued"}, exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    #12 check_reset("reset_state");
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk({imem_en, valid, done} == 3'b000, "idle_without_start", {imem_en, valid, done}, 0);

    // Directed three-word program, no stall
    prog.delete();
    prog.push_back(32'h0300_0010);
    prog.push_back(32'h0400_0020);
    prog.push_back(32'hFE00_0000);
    load(); pulse_start();
    run_to_done("basic", 0);
    pulse_start();
    repeat (4) @(posedge clk);
    #1 chk(done && !imem_en && !valid, "start_in_halt", {done, imem_en, valid}, 3'b100);

    // Long stall right after the first issue
    do_reset(); rand_prog(3); load(); pulse_start();
    wait_valid();
    @(posedge clk); #1 stall = 1'b1;
    repeat (9) @(posedge clk);
    #1 stall = 1'b0;
    run_to_done("long_stall", 0);

    // Stall on the issue cycle and the one after
    do_reset(); rand_prog(3); load();
    stall = 1'b1;
    pulse_start();
    wait_valid();
    @(posedge clk); @(posedge clk); #1 stall = 1'b0;
    run_to_done("early_stall", 0);

    // Random programs with random stall density
    for (int t = 0; t < 6; t++) begin
      do_reset(); rand_prog($urandom_range(1, 8)); load(); pulse_start();
      run_to_done("random", (t % 3) * 30);
    end

    // Asynchronous reset in the middle of a run, then a fresh program
    do_reset(); rand_prog(6); load(); pulse_start();
    repeat ($urandom_range(4, 10)) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset("mid_reset");
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    rand_prog(4); load(); pulse_start();
    run_to_done("after_reset", 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
